// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: FSM states, error codes,
// default frame header and the length-range helper.
package loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CHK,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CHECKSUM = 2'd1,
        ERR_LENGTH   = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // A frame may fill the whole memory (N == 2**addr_w) but not exceed it.
    function automatic logic len_overflow(input logic [15:0] n, input int unsigned addr_w);
        return ({16'd0, n} > (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach TIMEOUT.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: parses SYNC/LEN/DATA/CHK frames from a UART byte
// stream, writes 16-bit words to instruction memory and gates the CPU reset.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned TIMEOUT   = 50000,
    parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    state_t            state_q;
    err_t              err_q;
    logic [15:0]       len_q;
    logic [15:0]       count_q;
    logic [7:0]        chk_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic              cpu_reset_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic [15:0] len_d;
    logic [15:0] count_d;
    logic [7:0]  chk_d;
    logic        in_frame;
    logic        tmo_expired;

    assign len_d    = {len_q[15:8], rx_data};
    assign count_d  = count_q + 16'd1;
    assign chk_d    = chk_q ^ rx_data;
    assign in_frame = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CHK};

    loader_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk_i    (clk),
        .rst_i    (reset),
        .clr_i    (rx_valid || !in_frame),
        .en_i     (in_frame),
        .expired_o(tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            err_q       <= ERR_NONE;
            len_q       <= '0;
            count_q     <= '0;
            chk_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // Write pulse lasts one cycle; the address advances once it retires.
            we_q <= 1'b0;
            if (we_q) begin
                addr_q <= addr_q + ADDR_W'(1);
            end

            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q     <= ST_SYNC;
                        addr_q      <= '0;
                        count_q     <= '0;
                        chk_q       <= '0;
                        err_q       <= ERR_NONE;
                        cpu_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state_q <= ST_LEN_HI;
                    end
                end
                default: begin
                    // A byte arriving on the expiry cycle takes precedence.
                    if (rx_valid) begin
                        case (state_q)
                            ST_LEN_HI: begin
                                len_q[15:8] <= rx_data;
                                state_q     <= ST_LEN_LO;
                            end
                            ST_LEN_LO: begin
                                len_q <= len_d;
                                if (len_overflow(len_d, ADDR_W)) begin
                                    state_q <= ST_ERROR;
                                    err_q   <= ERR_LENGTH;
                                    busy_q  <= 1'b0;
                                    error_q <= 1'b1;
                                end else if (len_d == 16'd0) begin
                                    state_q <= ST_CHK;
                                end else begin
                                    state_q <= ST_DATA_HI;
                                end
                            end
                            ST_DATA_HI: begin
                                wdata_q[15:8] <= rx_data;
                                chk_q         <= chk_d;
                                state_q       <= ST_DATA_LO;
                            end
                            ST_DATA_LO: begin
                                wdata_q[7:0] <= rx_data;
                                chk_q        <= chk_d;
                                we_q         <= 1'b1;
                                count_q      <= count_d;
                                state_q      <= (count_d == len_q) ? ST_CHK : ST_DATA_HI;
                            end
                            ST_CHK: begin
                                busy_q <= 1'b0;
                                if (rx_data == chk_q) begin
                                    state_q     <= ST_DONE;
                                    done_q      <= 1'b1;
                                    cpu_reset_q <= 1'b0;
                                end else begin
                                    state_q <= ST_ERROR;
                                    err_q   <= ERR_CHECKSUM;
                                    error_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (tmo_expired) begin
                        state_q <= ST_ERROR;
                        err_q   <= ERR_TIMEOUT;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_q;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader that writes the instruction memory of the single-cycle CPU; it is the writer for the memory the CPU fetches from.
- Consumes a framed byte stream from a UART receiver, assembles 16-bit instruction words and writes them from address 0 upward.
- Holds the CPU in reset while loading and releases it only after a valid checksum.

Parameters:
- ADDR_W, 10, instruction memory address width in words
- TIMEOUT, 50000, maximum clk cycles allowed between bytes once a frame has started
- SYNC_BYTE, 8'hA5, frame header byte

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; arms the loader from IDLE, DONE or ERROR
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
- rx_data  input  8  received byte
- mem_we  output  1  instruction memory write enable, one cycle per word
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  16  instruction word, first byte in [15:8]
- cpu_reset  output  1  drives the CPU reset; high while loading or on error
- busy  output  1  high from arming until DONE or ERROR
- done  output  1  high in DONE
- error  output  1  high in ERROR
- err_code  output  2  0 none, 1 bad checksum, 2 length overflow, 3 timeout

Behaviour:
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO (word count N, 16-bit big-endian), then 2N data bytes, then CHK. CHK is the XOR of all 2N data bytes.
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset 1, busy 0, done 0, error 0, err_code 0. Word counter, checksum accumulator and timeout counter are all 0.
- Reset is honoured mid-frame. It aborts the load with no further writes. Already written words stay in memory and are not cleared.
- IDLE: rx_valid is ignored. start moves the FSM to SYNC and clears addr, count, checksum and err_code.
- SYNC: any byte other than SYNC_BYTE is discarded and the FSM stays in SYNC. SYNC has no timeout, because the frame has not begun.
- LEN_HI -> LEN_LO: N is latched from the two length bytes.
  - N > 2**ADDR_W: go to ERROR, code 2.
  - N == 0: go to CHK.
  - Otherwise: go to DATA_HI.
- DATA_HI: the byte is latched into wdata[15:8] and the FSM moves to DATA_LO.
- DATA_LO: the byte completes the word.
  - mem_we is asserted the following cycle for exactly one cycle, with mem_addr equal to the word index and mem_wdata registered.
  - mem_addr increments after the write.
  - After word N-1 the FSM goes to CHK; otherwise it returns to DATA_HI.
- Checksum: on every accepted data byte, chk <= chk ^ rx_data.
- CHK: a byte equal to the accumulator goes to DONE; otherwise to ERROR, code 1. The checksum is computed over the 8-bit data bytes only; the header and length bytes are excluded.
- Timeout: in LEN_HI through CHK, the counter resets on each rx_valid and otherwise increments. Reaching TIMEOUT goes to ERROR, code 3.
- Simultaneous timeout and rx_valid in the same cycle: the byte wins and the counter clears.
- DONE: cpu_reset drops to 0 on the cycle of entry. done = 1, busy = 0.
- ERROR: cpu_reset = 1, error = 1, busy = 0. The FSM stays in ERROR until reset or start.
- start while busy is ignored. start in DONE or ERROR re-arms the loader: cpu_reset returns to 1 the next cycle, done and error clear, and the FSM enters SYNC.
- rx_valid arriving on the cycle of the pending mem_we is accepted normally. The write pipeline is one register deep, and bytes arrive at least 2 cycles apart.
- cpu_reset = 1 in every state except DONE.

Decomposition:
- Shared package (loader_pkg): FSM state encoding (IDLE, SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERROR), err_code constants, default SYNC_BYTE.
- One natural sub-module, loader_timeout: a counter with clear, enable and an expired output, parameterised by TIMEOUT.
- The FSM, datapath registers and write pipeline stay in prog_loader.

Test Plan:
- Reset, start, frame A5 00 02 12 34 AB CD CHK=12^34^AB^CD=0x40:
  - writes 0x1234 to addr 0 and 0xABCD to addr 1, one mem_we cycle each.
  - done=1, cpu_reset falls on the cycle DONE is entered.
- Same frame with CHK=0x41 -> error=1, err_code=1, cpu_reset stays 1; both writes still occurred.
- Bytes 00 FF then A5 00 00 00 -> leading bytes discarded in SYNC; zero-length frame gives DONE with no mem_we.
- A5 04 01 with ADDR_W=10 (N=1025) -> ERROR, err_code=2, no mem_we.
- A5 00 01 12 then silence for TIMEOUT cycles -> ERROR, err_code=3.
- Same stall but the next byte arrives at exactly cycle TIMEOUT -> byte accepted and no error.
- Reset asserted asynchronously mid-DATA_LO:
  - all outputs return to reset values immediately, with no mem_we pulse.
  - a subsequent start and valid frame loads correctly from addr 0.
